// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS core: datapath widths, ALU op codes
// and the packed control bundle carried down the pipeline.
package mips_pkg;

  localparam int DATA_W  = 32;
  localparam int REG_AW  = 5;
  localparam int ALUOP_W = 4;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_e;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic alu_src;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare: an instruction in ID reads the destination of a load
// still sitting in EX. Also consumed by the forwarding unit.
module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_dest,
  output logic              hazard
);

  // $0 is hard-wired zero, so a load targeting it can never be a real dependency
  assign hazard = id_valid && ex_valid && ex_mem_read && (ex_dest != '0) &&
                  ((ex_dest == id_rs) || (ex_dest == id_rt));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: WB bypass around the register file, immediate
// extension, destination select, load-use bubble insertion and branch flush.
module id_ex_stage #(
  parameter int DATA_W  = mips_pkg::DATA_W,
  parameter int REG_AW  = mips_pkg::REG_AW,
  parameter int ALUOP_W = mips_pkg::ALUOP_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [REG_AW-1:0]  id_rs,
  input  logic [REG_AW-1:0]  id_rt,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic [DATA_W-1:0]  id_read_data1,
  input  logic [DATA_W-1:0]  id_read_data2,
  input  logic [15:0]        id_imm16,
  input  logic [4:0]         id_shamt,
  input  logic               id_zero_ext,
  input  logic               id_reg_write,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic               id_mem_to_reg,
  input  logic               id_alu_src,
  input  logic               id_reg_dst,
  input  logic [ALUOP_W-1:0] id_alu_op,
  input  logic               wb_reg_write,
  input  logic [REG_AW-1:0]  wb_rd,
  input  logic [DATA_W-1:0]  wb_data,
  input  logic               ex_flush,
  output logic               stall,
  output logic               ex_valid,
  output logic [REG_AW-1:0]  ex_rs,
  output logic [REG_AW-1:0]  ex_rt,
  output logic [REG_AW-1:0]  ex_dest,
  output logic [DATA_W-1:0]  ex_op_a,
  output logic [DATA_W-1:0]  ex_op_b,
  output logic [DATA_W-1:0]  ex_imm32,
  output logic [4:0]         ex_shamt,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_mem_to_reg,
  output logic               ex_alu_src,
  output logic [ALUOP_W-1:0] ex_alu_op
);

  import mips_pkg::*;

  logic               hazard;
  ctrl_t              id_ctrl;
  ctrl_t              ctrl_reg, ctrl_next;
  logic               valid_reg, valid_next;
  logic [REG_AW-1:0]  rs_reg, rs_next, rt_reg, rt_next, dest_reg, dest_next;
  logic [DATA_W-1:0]  op_a_reg, op_a_next, op_b_reg, op_b_next;
  logic [DATA_W-1:0]  imm_reg, imm_next, imm_ext;
  logic [4:0]         shamt_reg, shamt_next;
  logic [ALUOP_W-1:0] alu_op_reg, alu_op_next;

  logic [REG_AW-1:0]  src_idx [2];
  logic [DATA_W-1:0]  src_raw [2];
  logic [DATA_W-1:0]  src_byp [2];

  assign src_idx[0] = id_rs;
  assign src_idx[1] = id_rt;
  assign src_raw[0] = id_read_data1;
  assign src_raw[1] = id_read_data2;

  // The register file writes at the edge, so a same-cycle WB write is not yet visible on its read ports
  for (genvar gi = 0; gi < 2; gi++) begin : g_bypass
    assign src_byp[gi] = (wb_reg_write && (wb_rd != '0) && (wb_rd == src_idx[gi]))
                         ? wb_data : src_raw[gi];
  end

  assign imm_ext = id_zero_ext ? {{(DATA_W-16){1'b0}}, id_imm16}
                               : {{(DATA_W-16){id_imm16[15]}}, id_imm16};

  assign id_ctrl = '{reg_write:  id_reg_write,
                     mem_read:   id_mem_read,
                     mem_write:  id_mem_write,
                     mem_to_reg: id_mem_to_reg,
                     alu_src:    id_alu_src};

  hazard_detect #(.REG_AW(REG_AW)) u_hazard_detect (
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .ex_valid    (valid_reg),
    .ex_mem_read (ctrl_reg.mem_read),
    .ex_dest     (dest_reg),
    .hazard      (hazard)
  );

  // A flush redirects the front end, so holding PC/IF-ID would be wrong
  assign stall = hazard && !ex_flush;

  always_comb begin
    valid_next  = 1'b0;
    ctrl_next   = CTRL_BUBBLE;
    rs_next     = '0;
    rt_next     = '0;
    dest_next   = '0;
    op_a_next   = '0;
    op_b_next   = '0;
    imm_next    = '0;
    shamt_next  = '0;
    alu_op_next = '0;
    if (!ex_flush && !hazard) begin
      valid_next  = id_valid;
      ctrl_next   = id_valid ? id_ctrl : CTRL_BUBBLE;
      rs_next     = id_rs;
      rt_next     = id_rt;
      dest_next   = id_reg_dst ? id_rd : id_rt;
      op_a_next   = src_byp[0];
      op_b_next   = src_byp[1];
      imm_next    = imm_ext;
      shamt_next  = id_shamt;
      alu_op_next = id_alu_op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg  <= 1'b0;
      ctrl_reg   <= CTRL_BUBBLE;
      rs_reg     <= '0;
      rt_reg     <= '0;
      dest_reg   <= '0;
      op_a_reg   <= '0;
      op_b_reg   <= '0;
      imm_reg    <= '0;
      shamt_reg  <= '0;
      alu_op_reg <= '0;
    end else begin
      valid_reg  <= valid_next;
      ctrl_reg   <= ctrl_next;
      rs_reg     <= rs_next;
      rt_reg     <= rt_next;
      dest_reg   <= dest_next;
      op_a_reg   <= op_a_next;
      op_b_reg   <= op_b_next;
      imm_reg    <= imm_next;
      shamt_reg  <= shamt_next;
      alu_op_reg <= alu_op_next;
    end
  end

  assign ex_valid      = valid_reg;
  assign ex_rs         = rs_reg;
  assign ex_rt         = rt_reg;
  assign ex_dest       = dest_reg;
  assign ex_op_a       = op_a_reg;
  assign ex_op_b       = op_b_reg;
  assign ex_imm32      = imm_reg;
  assign ex_shamt      = shamt_reg;
  assign ex_reg_write  = ctrl_reg.reg_write;
  assign ex_mem_read   = ctrl_reg.mem_read;
  assign ex_mem_write  = ctrl_reg.mem_write;
  assign ex_mem_to_reg = ctrl_reg.mem_to_reg;
  assign ex_alu_src    = ctrl_reg.alu_src;
  assign ex_alu_op     = alu_op_reg;

endmodule
